// File: rtl/divider_nonrestoring_multi.sv
// Iterative non-restoring divider, unsigned or signed per operation, BITS_PER_CYCLE quotient bits per enabled clock.
// Define DIVIDER_EARLY_TERM_EN to skip leading-zero iterations of the numerator magnitude.
module divider_nonrestoring_multi #(
  parameter int DIV_NUM_BITS   = 8,
  parameter int DIV_DEN_BITS   = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    CLK,
  input  logic                    SRST_N,
  input  logic                    CE,
  input  logic [DIV_NUM_BITS-1:0] NUMERATOR_IN,
  input  logic [DIV_DEN_BITS-1:0] DENOMINATOR_IN,
  input  logic                    SIGNED_IN,
  input  logic                    start,
  output logic                    busy,
  output logic [DIV_NUM_BITS-1:0] QUOTENT_OUT,
  output logic [DIV_DEN_BITS-1:0] REMAINDER_OUT,
  output logic                    error,
  output logic                    done
);

  localparam int NB    = DIV_NUM_BITS;
  localparam int DB    = DIV_DEN_BITS;
  localparam int ITERS = DIV_NUM_BITS / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [NB-1:0] NUM_MIN = {1'b1, {(NB-1){1'b0}}};

  generate
    if (DIV_NUM_BITS % BITS_PER_CYCLE != 0) begin : g_bad_cfg
      $fatal(1, "BITS_PER_CYCLE must divide DIV_NUM_BITS exactly");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_ITER, S_CORRECT, S_OUTPUT, S_ERROR, S_OVF
  } state_t;

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt, cnt_load;
  logic                 busy_nxt, done_nxt, error_nxt;
  logic                 load_op, step_en, corr_en, out_en, ovf_en;

  logic                 num_neg, den_neg, is_ovf;
  logic [NB-1:0]        num_mag, num_load;
  logic [DB-1:0]        den_mag;

  logic [DB-1:0]        den_q;
  logic [NB-1:0]        quo_q, quo_step, quo_fix;
  logic signed [DB:0]   prem_q, prem_step;
  logic signed [DB+1:0] prem_sh;
  logic [DB-1:0]        rem_adj, rem_fix;
  logic                 quo_neg_q, rem_neg_q;

  function automatic logic [NB-1:0] neg_quo(input logic [NB-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [DB-1:0] neg_rem(input logic [DB-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    num_neg = SIGNED_IN & NUMERATOR_IN[NB-1];
    den_neg = SIGNED_IN & DENOMINATOR_IN[DB-1];
    num_mag = neg_quo(NUMERATOR_IN, num_neg);
    den_mag = neg_rem(DENOMINATOR_IN, den_neg);
    is_ovf  = SIGNED_IN && (NUMERATOR_IN == NUM_MIN) && (DENOMINATOR_IN == '1);
  end

`ifdef DIVIDER_EARLY_TERM_EN
  function automatic int count_lz(input logic [NB-1:0] v);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction

  int lz, skip;

  // Leading zero groups would only shift zeros through a zero remainder, so skip them.
  always_comb begin
    lz       = count_lz(num_mag);
    skip     = lz / BITS_PER_CYCLE;
    num_load = num_mag << (skip * BITS_PER_CYCLE);
    cnt_load = (skip >= ITERS) ? '0 : CNT_W'(ITERS - 1 - skip);
  end
`else
  always_comb begin
    num_load = num_mag;
    cnt_load = CNT_W'(ITERS - 1);
  end
`endif

  // Chained non-restoring steps on {partial remainder, quotient}.
  always_comb begin
    prem_step = prem_q;
    quo_step  = quo_q;
    prem_sh   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      prem_sh = {prem_step, quo_step[NB-1]};
      if (prem_step[DB]) prem_sh = prem_sh + $signed({2'b00, den_q});
      else               prem_sh = prem_sh - $signed({2'b00, den_q});
      prem_step = prem_sh[DB:0];
      quo_step  = {quo_step[NB-2:0], ~prem_sh[DB]};
    end
  end

  always_comb begin
    rem_adj = prem_q[DB] ? (prem_q[DB-1:0] + den_q) : prem_q[DB-1:0];
    rem_fix = neg_rem(rem_adj, rem_neg_q);
    quo_fix = neg_quo(quo_q, quo_neg_q);
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    load_op   = 1'b0;
    step_en   = 1'b0;
    corr_en   = 1'b0;
    out_en    = 1'b0;
    ovf_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_op = 1'b1;
          if (DENOMINATOR_IN == '0) begin
            state_nxt = S_ERROR;
            cnt_nxt   = CNT_W'(1);
          end else if (is_ovf) begin
            state_nxt = S_OVF;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = S_ITER;
            cnt_nxt   = cnt_load;
          end
        end
      end
      S_ITER: begin
        step_en  = 1'b1;
        busy_nxt = 1'b1;
        if (cnt_q == '0) state_nxt = S_CORRECT;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end
      S_CORRECT: begin
        corr_en   = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_en    = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      // Fault states wait one extra enabled cycle before reporting.
      S_ERROR, S_OVF: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          done_nxt  = 1'b1;
          error_nxt = 1'b1;
          ovf_en    = (state_q == S_OVF);
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      QUOTENT_OUT   <= '0;
      REMAINDER_OUT <= '0;
    end else if (CE) begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      error   <= error_nxt;
      if (out_en) begin
        QUOTENT_OUT   <= quo_q;
        REMAINDER_OUT <= prem_q[DB-1:0];
      end else if (ovf_en) begin
        QUOTENT_OUT   <= NUM_MIN;
        REMAINDER_OUT <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (load_op) begin
        den_q     <= den_mag;
        quo_q     <= num_load;
        prem_q    <= '0;
        quo_neg_q <= num_neg ^ den_neg;
        rem_neg_q <= num_neg;
      end else if (step_en) begin
        prem_q <= prem_step;
        quo_q  <= quo_step;
      end else if (corr_en) begin
        prem_q <= {1'b0, rem_fix};
        quo_q  <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_divider_nonrestoring_multi.sv
// Bench for divider_nonrestoring_multi: a 1-bit/cycle instance driven from a vector table and
// a 2-bit/cycle instance exercising ignored start, clock-enable stall and mid-run reset.
module tb_divider_nonrestoring_multi;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       SRST_N, CE, SIGNED_IN, start_a, start_b;
  logic [7:0] NUMERATOR_IN, DENOMINATOR_IN;
  logic       busy_a, err_a, done_a, busy_b, err_b, done_b;
  logic [7:0] q_a, r_a, q_b, r_b;

  int errors = 0;
  int checks = 0;

  divider_nonrestoring_multi #(.DIV_NUM_BITS(8), .DIV_DEN_BITS(8), .BITS_PER_CYCLE(1)) dut_a (
    .CLK(CLK), .SRST_N(SRST_N), .CE(CE),
    .NUMERATOR_IN(NUMERATOR_IN), .DENOMINATOR_IN(DENOMINATOR_IN), .SIGNED_IN(SIGNED_IN),
    .start(start_a), .busy(busy_a), .QUOTENT_OUT(q_a), .REMAINDER_OUT(r_a),
    .error(err_a), .done(done_a)
  );

  divider_nonrestoring_multi #(.DIV_NUM_BITS(8), .DIV_DEN_BITS(8), .BITS_PER_CYCLE(2)) dut_b (
    .CLK(CLK), .SRST_N(SRST_N), .CE(CE),
    .NUMERATOR_IN(NUMERATOR_IN), .DENOMINATOR_IN(DENOMINATOR_IN), .SIGNED_IN(SIGNED_IN),
    .start(start_b), .busy(busy_b), .QUOTENT_OUT(q_b), .REMAINDER_OUT(r_b),
    .error(err_b), .done(done_b)
  );

  typedef struct {
    logic [7:0] num;
    logic [7:0] den;
    logic       sgn;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    logic       keep;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  vec_t       vecs[14];
  logic [7:0] last_q, last_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected edges from the start-sampling edge to done.
  function automatic int lat_of(input logic [7:0] n, input logic [7:0] d, input logic s, input int bpc);
    int it;
`ifdef DIVIDER_EARLY_TERM_EN
    logic [7:0] mag;
    int         lz;
`endif
    if (d == 8'h00 || (s && n == 8'h80 && d == 8'hFF)) return 2;
    it = 8 / bpc;
`ifdef DIVIDER_EARLY_TERM_EN
    mag = (s && n[7]) ? -n : n;
    lz  = 0;
    for (int i = 7; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
    it = it - lz / bpc;
    if (it < 1) it = 1;
`endif
    return it + 2;
  endfunction

  task automatic start_op(input bit b2, input logic [7:0] n, input logic [7:0] d, input logic s);
    @(negedge CLK);
    NUMERATOR_IN   = n;
    DENOMINATOR_IN = d;
    SIGNED_IN      = s;
    if (b2) start_b = 1'b1;
    else    start_a = 1'b1;
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("done_drops_after_start", 32'(b2 ? done_b : done_a), 0);
  endtask

  task automatic finish_op(input bit b2, input int edges0, input int extra, input string tag);
    exp_t e;
    int   edges;
    logic dn;
    if (sbq.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(sbq.size()), 1);
      return;
    end
    edges = edges0;
    dn    = b2 ? done_b : done_a;
    while (!dn && edges < 100) begin
      @(posedge CLK);
      #1;
      edges++;
      dn = b2 ? done_b : done_a;
      if (!dn) chk({tag, "_busy"}, 32'(b2 ? busy_b : busy_a), 32'(!sbq[0].err));
    end
    chk({tag, "_done_seen"}, 32'(dn), 1);
    if (!dn) return;
    e = sbq.pop_front();
    chk({tag, "_latency"}, 32'(edges), 32'(e.lat + extra));
    chk({tag, "_quotient"}, 32'(b2 ? q_b : q_a), 32'(e.q));
    chk({tag, "_remainder"}, 32'(b2 ? r_b : r_a), 32'(e.r));
    chk({tag, "_error"}, 32'(b2 ? err_b : err_a), 32'(e.err));
    chk({tag, "_busy_at_done"}, 32'(b2 ? busy_b : busy_a), 0);
  endtask

  initial begin
    exp_t e;
    int   edges;
    int   seen;

    SRST_N = 1'b0; CE = 1'b1; start_a = 1'b0; start_b = 1'b0;
    NUMERATOR_IN = '0; DENOMINATOR_IN = '0; SIGNED_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_q_a", 32'(q_a), 0);       chk("rst_r_a", 32'(r_a), 0);
    chk("rst_done_a", 32'(done_a), 0); chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_err_a", 32'(err_a), 0);
    chk("rst_q_b", 32'(q_b), 0);       chk("rst_r_b", 32'(r_b), 0);
    chk("rst_done_b", 32'(done_b), 0); chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_err_b", 32'(err_b), 0);
    @(negedge CLK);
    SRST_N = 1'b1;

    //          num    den    sgn   q      r      err   keep
    vecs[0]  = '{8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0};
    vecs[1]  = '{8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{8'h9C, 8'hF9, 1'b0, 8'h00, 8'h9C, 1'b0, 1'b0};
    vecs[4]  = '{8'd55, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[9]  = '{8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'h80, 1'b1, 8'h00, 8'h7F, 1'b0, 1'b0};
    vecs[11] = '{8'h05, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{8'h03, 8'h01, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{8'hFF, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};

    last_q = '0;
    last_r = '0;
    for (int i = 0; i < 14; i++) begin
      e.q   = vecs[i].keep ? last_q : vecs[i].q;
      e.r   = vecs[i].keep ? last_r : vecs[i].r;
      e.err = vecs[i].err;
      e.lat = lat_of(vecs[i].num, vecs[i].den, vecs[i].sgn, 1);
      last_q = e.q;
      last_r = e.r;
      sbq.push_back(e);
      start_op(1'b0, vecs[i].num, vecs[i].den, vecs[i].sgn);
      finish_op(1'b0, 0, 0, $sformatf("vec%0d", i));
    end

    // Second start while iterating must be dropped.
    e = '{8'd15, 8'd15, 1'b0, lat_of(8'd255, 8'd16, 1'b0, 2)};
    sbq.push_back(e);
    start_op(1'b1, 8'd255, 8'd16, 1'b0);
    @(posedge CLK); #1;
    chk("ign_busy_e1", 32'(busy_b), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    NUMERATOR_IN = 8'h10; DENOMINATOR_IN = 8'h03; start_b = 1'b1;
    @(posedge CLK); #1;
    start_b = 1'b0;
    finish_op(1'b1, 3, 0, "ign_start");
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (done_b) seen++;
    end
    chk("ign_no_second_done", 32'(seen), 0);
    chk("ign_q_held", 32'(q_b), 15);

    // Clock enable low for three cycles mid-run.
    sbq.push_back(e);
    start_op(1'b1, 8'd255, 8'd16, 1'b0);
    repeat (2) begin @(posedge CLK); #1; end
    @(negedge CLK);
    CE = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("ce_stall_busy_frozen", 32'(busy_b), 1);
    @(negedge CLK);
    CE = 1'b1;
    finish_op(1'b1, 5, 3, "ce_stall");

    // Reset at edge 4 abandons the operation.
    start_op(1'b1, 8'd255, 8'd16, 1'b0);
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    SRST_N = 1'b0;
    @(posedge CLK); #1;
    chk("mrst_q", 32'(q_b), 0);       chk("mrst_r", 32'(r_b), 0);
    chk("mrst_done", 32'(done_b), 0); chk("mrst_busy", 32'(busy_b), 0);
    chk("mrst_err", 32'(err_b), 0);
    @(negedge CLK);
    SRST_N = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (done_b) seen++;
    end
    chk("mrst_abandoned", 32'(seen), 0);
    e = '{8'd14, 8'd2, 1'b0, lat_of(8'd100, 8'd7, 1'b0, 2)};
    sbq.push_back(e);
    start_op(1'b1, 8'd100, 8'd7, 1'b0);
    finish_op(1'b1, 0, 0, "post_rst");

    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
